// File: rtl/bsg_manycore_pod_reset_sequencer_if.sv
// Pod reset bundle between the per-pod reset sources and the pod array.
interface bsg_manycore_pod_reset_sequencer_if #(
  parameter int num_pods_x_p  = 2,
  parameter int num_pods_y_p  = 2,
  parameter int num_tiles_x_p = 4
);
  logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                    pod_reset_req;
  logic [num_pods_y_p-1:0][num_pods_x_p-1:0][num_tiles_x_p-1:0] pod_reset;
  logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                    pod_held;
  logic                                                          busy;

  modport master (output pod_reset_req, input pod_reset, pod_held, busy);
  modport slave  (input pod_reset_req, output pod_reset, pod_held, busy);
endinterface

// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// Per-pod reset distribution: assertions pass straight through at fixed latency,
// releases are serialized lowest-index-first with a fixed gap between them.
module bsg_manycore_pod_reset_sequencer #(
  parameter int num_pods_x_p     = 2,
  parameter int num_pods_y_p     = 2,
  parameter int num_tiles_x_p    = 4,
  parameter int reset_depth_p    = 3,
  parameter int stagger_cycles_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  bsg_manycore_pod_reset_sequencer_if.slave  pod_if
);

  localparam int num_pods_lp  = num_pods_x_p * num_pods_y_p;
  localparam int cnt_width_lp = (stagger_cycles_p > 0) ? $clog2(stagger_cycles_p + 1) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_load_lp =
    (stagger_cycles_p > 0) ? cnt_width_lp'(stagger_cycles_p - 1) : '0;

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [num_pods_lp-1:0]  held_q, held_d;
  logic [num_pods_lp-1:0]  req, pending, out_stage;
  logic                    found;
  logic                    busy;
  logic [num_pods_lp*num_tiles_x_p-1:0] reset_flat;

  // Packed [y][x] flattens so bit index equals p = y*num_pods_x_p + x.
  assign req     = pod_if.pod_reset_req;
  assign pending = held_q & ~req;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q | req;
    found   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          // pending excludes requesting pods, so a same-cycle assert always wins
          for (int unsigned p = 0; p < num_pods_lp; p++) begin
            if (pending[p] && !found) begin
              held_d[p] = 1'b0;
              found     = 1'b1;
            end
          end
          if (stagger_cycles_p > 0) begin
            cnt_d   = cnt_load_lp;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  generate
    if (reset_depth_p > 1) begin : g_pipe
      logic [num_pods_lp-1:0] stage_q [reset_depth_p-1];
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int unsigned i = 0; i < reset_depth_p - 1; i++) stage_q[i] <= '1;
        end else begin
          stage_q[0] <= held_q;
          for (int unsigned i = 1; i < reset_depth_p - 1; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign out_stage = stage_q[reset_depth_p-2];
    end else begin : g_nopipe
      assign out_stage = held_q;
    end
  endgenerate

  always_comb begin
    reset_flat = '0;
    for (int unsigned p = 0; p < num_pods_lp; p++) begin
      for (int unsigned t = 0; t < num_tiles_x_p; t++) begin
        reset_flat[p*num_tiles_x_p + t] = out_stage[p];
      end
    end
    // Held all-1 makes everything look pending during reset; mask that off.
    busy = ~reset_i & ((state_q == GAP) | (|pending));
  end

  assign pod_if.pod_reset = reset_flat;
  assign pod_if.pod_held  = held_q;
  assign pod_if.busy      = busy;

endmodule

// File: tb/tb_bsg_manycore_pod_reset_sequencer.sv
// Scoreboarded bench: three 2x2 instances (stagger 16, stagger 0, stagger 16 with mid-sequence reset).
module tb_bsg_manycore_pod_reset_sequencer;
  localparam int X = 2, Y = 2, T = 4;
  localparam int K_RST = 0, K_HELD = 1, K_BUSY = 2;
  localparam int END_CYC = 230;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_count = 0;
  always @(posedge clk) edge_count <= edge_count + 1;

  logic rst_a, rst_b, rst_c;

  bsg_manycore_pod_reset_sequencer_if #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T)) ifa ();
  bsg_manycore_pod_reset_sequencer_if #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T)) ifb ();
  bsg_manycore_pod_reset_sequencer_if #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T)) ifc ();

  bsg_manycore_pod_reset_sequencer #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T),
    .reset_depth_p(3), .stagger_cycles_p(16)) dut_a (.clk_i(clk), .reset_i(rst_a), .pod_if(ifa.slave));
  bsg_manycore_pod_reset_sequencer #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T),
    .reset_depth_p(3), .stagger_cycles_p(0)) dut_b (.clk_i(clk), .reset_i(rst_b), .pod_if(ifb.slave));
  bsg_manycore_pod_reset_sequencer #(.num_pods_x_p(X), .num_pods_y_p(Y), .num_tiles_x_p(T),
    .reset_depth_p(3), .stagger_cycles_p(16)) dut_c (.clk_i(clk), .reset_i(rst_c), .pod_if(ifc.slave));

  typedef struct {
    int         cyc;
    int         dut;
    int         kind;
    int         pod;
    logic [3:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_at(input int cyc, input int dut, input int kind, input int pod, input logic [3:0] exp);
    chk_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.pod = pod; e.exp = exp;
    sb.push_back(e);
  endtask

  // Cycle k is the interval after the (k+4)th rising edge; inputs change 1 time unit into it.
  task automatic go(input int k);
    while (edge_count < k + 4) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic string kname(input int kind);
    case (kind)
      K_RST:   return "pod_reset";
      K_HELD:  return "pod_held";
      default: return "busy";
    endcase
  endfunction

  function automatic logic [3:0] actual(input int dut, input int kind, input int pod);
    logic [Y-1:0][X-1:0][T-1:0] r;
    logic [Y-1:0][X-1:0]        h;
    logic                       b;
    int y, x;
    y = pod / X;
    x = pod % X;
    case (dut)
      0:       begin r = ifa.pod_reset; h = ifa.pod_held; b = ifa.busy; end
      1:       begin r = ifb.pod_reset; h = ifb.pod_held; b = ifb.busy; end
      default: begin r = ifc.pod_reset; h = ifc.pod_held; b = ifc.busy; end
    endcase
    case (kind)
      K_RST:   return r[y][x];
      K_HELD:  return {3'b000, h[y][x]};
      default: return {3'b000, b};
    endcase
  endfunction

  always @(negedge clk) begin
    int         c;
    logic [3:0] act;
    c = edge_count - 4;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= c) begin
        n_tests++;
        act = actual(sb[i].dut, sb[i].kind, sb[i].pod);
        if (sb[i].cyc < c) begin
          n_fail++;
          $display("FAIL missed %s dut%0d pod%0d cyc %0d", kname(sb[i].kind), sb[i].dut, sb[i].pod, sb[i].cyc);
        end else if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s dut%0d pod%0d cyc %0d: got %h want %h",
                   kname(sb[i].kind), sb[i].dut, sb[i].pod, c, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
    if (c == END_CYC) begin
      if (sb.size() != 0) begin
        $display("FAIL unchecked: %0d expectations never reached", sb.size());
        n_tests += sb.size();
        n_fail  += sb.size();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Instance A: power-up, single pulse, dual hold, re-request during a gap.
  initial begin
    int falls[4];
    falls = '{3, 20, 37, 54};
    rst_a = 1'b1;
    ifa.pod_reset_req = '0;
    for (int p = 0; p < 4; p++) begin
      expect_at(-2, 0, K_RST, p, 4'hF);
      expect_at(-1, 0, K_RST, p, 4'hF);
      expect_at(falls[p] - 1, 0, K_RST, p, 4'hF);
      expect_at(falls[p],     0, K_RST, p, 4'h0);
    end
    expect_at(-1, 0, K_BUSY, 0, 4'h0);
    expect_at(0,  0, K_BUSY, 0, 4'h1);
    expect_at(30, 0, K_BUSY, 0, 4'h1);
    expect_at(67, 0, K_BUSY, 0, 4'h1);
    expect_at(68, 0, K_BUSY, 0, 4'h0);
    expect_at(0,  0, K_HELD, 0, 4'h1);
    expect_at(1,  0, K_HELD, 0, 4'h0);
    expect_at(52, 0, K_HELD, 3, 4'h0);
    // single-cycle request on pod 2 at cycle 80
    expect_at(80, 0, K_HELD, 2, 4'h0);
    expect_at(81, 0, K_HELD, 2, 4'h1);
    expect_at(82, 0, K_HELD, 2, 4'h0);
    expect_at(82, 0, K_RST,  2, 4'h0);
    expect_at(83, 0, K_RST,  2, 4'hF);
    expect_at(84, 0, K_RST,  2, 4'h0);
    expect_at(83, 0, K_RST,  0, 4'h0);
    expect_at(83, 0, K_RST,  1, 4'h0);
    expect_at(83, 0, K_RST,  3, 4'h0);
    expect_at(81, 0, K_BUSY, 0, 4'h1);
    expect_at(97, 0, K_BUSY, 0, 4'h1);
    expect_at(98, 0, K_BUSY, 0, 4'h0);
    // pods 0 and 3 held 100..109, dropped together at 110
    expect_at(102, 0, K_RST, 0, 4'h0);
    expect_at(103, 0, K_RST, 0, 4'hF);
    expect_at(103, 0, K_RST, 3, 4'hF);
    expect_at(112, 0, K_RST, 0, 4'hF);
    expect_at(113, 0, K_RST, 0, 4'h0);
    expect_at(120, 0, K_RST, 1, 4'h0);
    expect_at(129, 0, K_RST, 3, 4'hF);
    expect_at(130, 0, K_RST, 3, 4'h0);
    // all held 140..149; pod 0 re-requested 170..171 while in the gap after pod 1
    for (int p = 0; p < 4; p++) expect_at(143, 0, K_RST, p, 4'hF);
    expect_at(153, 0, K_RST, 0, 4'h0);
    expect_at(169, 0, K_RST, 1, 4'hF);
    expect_at(170, 0, K_RST, 1, 4'h0);
    expect_at(172, 0, K_RST, 0, 4'h0);
    expect_at(173, 0, K_RST, 0, 4'hF);
    expect_at(184, 0, K_BUSY, 0, 4'h1);
    expect_at(186, 0, K_RST, 0, 4'hF);
    expect_at(187, 0, K_RST, 0, 4'h0);
    expect_at(203, 0, K_RST, 2, 4'hF);
    expect_at(204, 0, K_RST, 2, 4'h0);
    expect_at(220, 0, K_RST, 3, 4'hF);
    expect_at(221, 0, K_RST, 3, 4'h0);

    go(0);   rst_a = 1'b0;
    go(80);  ifa.pod_reset_req = 4'b0100;
    go(81);  ifa.pod_reset_req = '0;
    go(100); ifa.pod_reset_req = 4'b1001;
    go(110); ifa.pod_reset_req = '0;
    go(140); ifa.pod_reset_req = '1;
    go(150); ifa.pod_reset_req = '0;
    go(170); ifa.pod_reset_req = 4'b0001;
    go(172); ifa.pod_reset_req = '0;
  end

  // Instance B: zero stagger, back-to-back releases.
  initial begin
    rst_b = 1'b1;
    ifb.pod_reset_req = '0;
    for (int p = 0; p < 4; p++) begin
      expect_at(2 + p, 1, K_RST, p, 4'hF);
      expect_at(3 + p, 1, K_RST, p, 4'h0);
    end
    expect_at(3,  1, K_BUSY, 0, 4'h1);
    expect_at(4,  1, K_BUSY, 0, 4'h0);
    expect_at(10, 1, K_BUSY, 0, 4'h0);
    go(0); rst_b = 1'b0;
  end

  // Instance C: reset pulse during cycle 25 restarts the sequence from pod 0.
  initial begin
    rst_c = 1'b1;
    ifc.pod_reset_req = '0;
    expect_at(25, 2, K_RST,  1, 4'h0);
    expect_at(26, 2, K_RST,  1, 4'hF);
    expect_at(26, 2, K_RST,  0, 4'hF);
    expect_at(26, 2, K_HELD, 1, 4'h1);
    expect_at(26, 2, K_BUSY, 0, 4'h1);
    expect_at(28, 2, K_RST,  0, 4'hF);
    expect_at(29, 2, K_RST,  0, 4'h0);
    expect_at(45, 2, K_RST,  1, 4'hF);
    expect_at(46, 2, K_RST,  1, 4'h0);
    expect_at(62, 2, K_RST,  2, 4'hF);
    expect_at(63, 2, K_RST,  2, 4'h0);
    expect_at(79, 2, K_RST,  3, 4'hF);
    expect_at(80, 2, K_RST,  3, 4'h0);
    go(0);  rst_c = 1'b0;
    go(25); rst_c = 1'b1;
    go(26); rst_c = 1'b0;
  end

endmodule
